// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the unified-memory port arbiter:
//   - RISC-V load/store funct3 size codes
//   - arbiter FSM state encodings
//   - grant owner enumeration
//   - byte mask helper for an access size
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

   // funct3 size codes shared by loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // arbiter FSM states
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC1 = 2'd1;
   localparam logic [1:0] ACC2 = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } grant_e;

   // Byte mask for the access size encoded in funct3; zero for unknown codes.
   function automatic logic [7:0] size_mask(input logic [2:0] funct3);
      logic [7:0] mask;
      case (funct3)
         F3_B, F3_BU: mask = 8'h01;
         F3_H, F3_HU: mask = 8'h03;
         F3_W:        mask = 8'h0F;
         default:     mask = 8'h00;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational lane steering for a byte-addressed access on a 32-bit memory.
//   i_we       store (1) / load (0), only used to judge funct3 legality
//   i_funct3   RISC-V load/store funct3
//   i_off      byte offset inside the word (addr[1:0])
//   i_wdata    store data, right-justified
//   i_rd64     {second word, first word} read back from memory
//   o_be8      byte enables across the two-word window
//   o_w64      store data shifted into its lanes across the two-word window
//   o_split    access touches the second word
//   o_illegal  funct3 not valid for this direction
//   o_rdata    sign/zero-extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [63:0] i_rd64,
   output logic [7:0]  o_be8,
   output logic [63:0] o_w64,
   output logic        o_split,
   output logic        o_illegal,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_mask;
   logic [4:0]  w_shamt;
   logic [31:0] w_rd_lo;

   assign w_mask  = size_mask(i_funct3);
   assign w_shamt = {i_off, 3'b000};

   // Unsigned sizes exist only for loads; anything without a size is illegal.
   assign o_illegal = (w_mask == 8'h00) || (i_we && i_funct3[2]);

   assign o_be8   = o_illegal ? 8'h00 : (w_mask << i_off);
   assign o_split = |o_be8[7:4];
   assign o_w64   = {32'h0000_0000, i_wdata} << w_shamt;

   // Bring the addressed byte down to lane 0 of the two-word window.
   assign w_rd_lo = 32'(i_rd64 >> w_shamt);

   // Extend the low bytes of the aligned read according to the load type.
   always_comb begin
      o_rdata = 32'h0000_0000;
      case (i_funct3)
         F3_B:    o_rdata = {{24{w_rd_lo[7]}}, w_rd_lo[7:0]};
         F3_H:    o_rdata = {{16{w_rd_lo[15]}}, w_rd_lo[15:0]};
         F3_W:    o_rdata = w_rd_lo;
         F3_BU:   o_rdata = {24'h00_0000, w_rd_lo[7:0]};
         F3_HU:   o_rdata = {16'h0000, w_rd_lo[15:0]};
         default: o_rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported 32-bit memory between instruction fetch and the
// data load/store path. Round-robin on conflict, splits word-crossing data
// accesses into two memory cycles, and returns extended load data.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_if_*            fetch request (held until o_if_ack), response, error
//   i_d_*             data request (held until o_d_ack), response, error
//   o_mem_*           registered memory command (word-aligned address)
//   i_mem_rdata       memory read data, valid the cycle after a read command
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_ack,
   output logic [31:0]       o_if_rdata,
   output logic              o_if_err,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [2:0]        i_d_funct3,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [31:0]       i_d_wdata,
   output logic              o_d_ack,
   output logic [31:0]       o_d_rdata,
   output logic              o_d_err,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [3:0]        o_mem_be,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata
);

   logic [1:0]        r_state;
   grant_e            r_last_grant;
   grant_e            r_gnt;
   logic              r_we;
   logic              r_split;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [ADDR_W-1:0] r_addr2;
   logic [3:0]        r_be2;
   logic [31:0]       r_wdata2;
   logic [31:0]       r_word1;
   logic              r_if_ack;
   logic              r_if_err;
   logic              r_d_ack;
   logic              r_d_err;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [3:0]        r_mem_be;
   logic [31:0]       r_mem_wdata;

   logic              w_gnt_any;
   logic              w_gnt_fetch;
   logic [ADDR_W-1:0] w_d_word;
   logic              w_al_we;
   logic [2:0]        w_al_funct3;
   logic [1:0]        w_al_off;
   logic [63:0]       w_rd64;
   logic [7:0]        w_be8;
   logic [63:0]       w_w64;
   logic              w_split;
   logic              w_illegal;
   logic [31:0]       w_rdata_ext;

   // On conflict the requester that did not win last time is served.
   assign w_gnt_any   = i_if_req | i_d_req;
   assign w_gnt_fetch = i_if_req & (~i_d_req | (r_last_grant == DATA));
   assign w_d_word    = {i_d_addr[ADDR_W-1:2], 2'b00};

   // The aligner decodes live inputs while arbitrating and the latched
   // request afterwards, when it extends the returning load data.
   assign w_al_we     = (r_state == IDLE) ? i_d_we            : r_we;
   assign w_al_funct3 = (r_state == IDLE) ? i_d_funct3        : r_funct3;
   assign w_al_off    = (r_state == IDLE) ? i_d_addr[1:0]     : r_off;
   assign w_rd64      = r_split ? {i_mem_rdata, r_word1} : {32'h0000_0000, i_mem_rdata};

   mem_lane_align u_align (
      .i_we      (w_al_we),
      .i_funct3  (w_al_funct3),
      .i_off     (w_al_off),
      .i_wdata   (i_d_wdata),
      .i_rd64    (w_rd64),
      .o_be8     (w_be8),
      .o_w64     (w_w64),
      .o_split   (w_split),
      .o_illegal (w_illegal),
      .o_rdata   (w_rdata_ext)
   );

   // Arbitration, access sequencing and registered command/ack generation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_last_grant <= DATA;
         r_gnt        <= FETCH;
         r_we         <= 1'b0;
         r_split      <= 1'b0;
         r_funct3     <= 3'b000;
         r_off        <= 2'b00;
         r_addr2      <= {ADDR_W{1'b0}};
         r_be2        <= 4'b0000;
         r_wdata2     <= 32'h0000_0000;
         r_word1      <= 32'h0000_0000;
         r_if_ack     <= 1'b0;
         r_if_err     <= 1'b0;
         r_d_ack      <= 1'b0;
         r_d_err      <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= {ADDR_W{1'b0}};
         r_mem_be     <= 4'b0000;
         r_mem_wdata  <= 32'h0000_0000;
      end else begin
         // Commands and acks are single-cycle unless re-armed below.
         r_if_ack    <= 1'b0;
         r_if_err    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_d_err     <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'h0000_0000;
         case (r_state)
            IDLE: begin
               if (w_gnt_any) begin
                  r_gnt        <= w_gnt_fetch ? FETCH : DATA;
                  r_last_grant <= w_gnt_fetch ? FETCH : DATA;
                  if (w_gnt_fetch) begin
                     r_we    <= 1'b0;
                     r_split <= 1'b0;
                     if (|i_if_addr[1:0]) begin
                        // Misaligned fetch is answered without touching memory.
                        r_state  <= RESP;
                        r_if_ack <= 1'b1;
                        r_if_err <= 1'b1;
                     end else begin
                        r_state    <= ACC1;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= i_if_addr;
                        r_mem_be   <= 4'b1111;
                     end
                  end else begin
                     r_we     <= i_d_we;
                     r_funct3 <= i_d_funct3;
                     r_off    <= i_d_addr[1:0];
                     r_split  <= w_split;
                     r_addr2  <= w_d_word + ADDR_W'(4);
                     r_be2    <= w_be8[7:4];
                     r_wdata2 <= i_d_we ? w_w64[63:32] : 32'h0000_0000;
                     if (w_illegal) begin
                        r_state <= RESP;
                        r_d_ack <= 1'b1;
                        r_d_err <= 1'b1;
                     end else begin
                        r_state     <= ACC1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= i_d_we;
                        r_mem_addr  <= w_d_word;
                        r_mem_be    <= w_be8[3:0];
                        r_mem_wdata <= i_d_we ? w_w64[31:0] : 32'h0000_0000;
                     end
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            ACC1: begin
               if (r_split) begin
                  r_state     <= ACC2;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= r_we;
                  r_mem_addr  <= r_addr2;
                  r_mem_be    <= r_be2;
                  r_mem_wdata <= r_wdata2;
               end else begin
                  r_state  <= RESP;
                  r_if_ack <= (r_gnt == FETCH);
                  r_d_ack  <= (r_gnt == DATA);
               end
            end
            ACC2: begin
               // First word's read data is on i_mem_rdata during this cycle.
               r_word1  <= i_mem_rdata;
               r_state  <= RESP;
               r_if_ack <= (r_gnt == FETCH);
               r_d_ack  <= (r_gnt == DATA);
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_if_ack    = r_if_ack;
   assign o_if_err    = r_if_err;
   assign o_if_rdata  = (r_if_ack & ~r_if_err) ? i_mem_rdata : 32'h0000_0000;
   assign o_d_ack     = r_d_ack;
   assign o_d_err     = r_d_err;
   assign o_d_rdata   = (r_d_ack & ~r_d_err & ~r_we) ? w_rdata_ext : 32'h0000_0000;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small word memory model that
// logs every memory command it sees.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } cmd_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_ack;
   logic [31:0] o_if_rdata;
   logic        o_if_err;
   logic        i_d_req;
   logic        i_d_we;
   logic [2:0]  i_d_funct3;
   logic [31:0] i_d_addr;
   logic [31:0] i_d_wdata;
   logic        o_d_ack;
   logic [31:0] o_d_rdata;
   logic        o_d_err;
   logic        o_mem_en;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata = 32'h0;

   logic [31:0] mem [0:1023];
   cmd_t        cmd_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_if_req    (i_if_req),
      .i_if_addr   (i_if_addr),
      .o_if_ack    (o_if_ack),
      .o_if_rdata  (o_if_rdata),
      .o_if_err    (o_if_err),
      .i_d_req     (i_d_req),
      .i_d_we      (i_d_we),
      .i_d_funct3  (i_d_funct3),
      .i_d_addr    (i_d_addr),
      .i_d_wdata   (i_d_wdata),
      .o_d_ack     (o_d_ack),
      .o_d_rdata   (o_d_rdata),
      .o_d_err     (o_d_err),
      .o_mem_en    (o_mem_en),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_be    (o_mem_be),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_rdata (i_mem_rdata)
   );

   // Memory model: byte-enabled writes, reads return data one cycle later.
   always @(posedge clk) begin
      if (o_mem_en) begin
         cmd_q.push_back({o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata});
         if (o_mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (o_mem_be[b]) mem[o_mem_addr[11:2]][b*8 +: 8] = o_mem_wdata[b*8 +: 8];
            end
         end else begin
            i_mem_rdata <= mem[o_mem_addr[11:2]];
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic cmd_t get_cmd(input int i);
      cmd_t c;
      c = '1;
      if (i < cmd_q.size()) c = cmd_q[i];
      return c;
   endfunction

   task automatic do_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rd, output logic err);
      logic seen;
      @(negedge clk);
      cmd_q.delete();
      i_d_req = 1'b1; i_d_we = we; i_d_funct3 = f3; i_d_addr = addr; i_d_wdata = wdata;
      lat = 0; seen = 1'b0; rd = 32'hX; err = 1'bX;
      while (!seen && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (o_d_ack) begin
            seen = 1'b1; rd = o_d_rdata; err = o_d_err;
         end
      end
      i_d_req = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] addr, output int lat,
                           output logic [31:0] rd, output logic err);
      logic seen;
      @(negedge clk);
      cmd_q.delete();
      i_if_req = 1'b1; i_if_addr = addr;
      lat = 0; seen = 1'b0; rd = 32'hX; err = 1'bX;
      while (!seen && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (o_if_ack) begin
            seen = 1'b1; rd = o_if_rdata; err = o_if_err;
         end
      end
      i_if_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        err;
      logic [3:0]  order;
      int          n_ack;
      int          n_derr;
      int          stray;

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[32'h100 >> 2] = 32'h0051_0513;
      mem[32'h2FC >> 2] = 32'h80AA_BBCC;
      mem[32'h300 >> 2] = 32'h1234_56FF;

      i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = 32'h0;
      i_d_req = 1'b0; i_d_we = 1'b0; i_d_funct3 = 3'b000; i_d_addr = 32'h0; i_d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      i_rst = 1'b0;

      check("rst_mem_en", 128'(o_mem_en), 128'(0));
      check("rst_mem_cmd", 128'({o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata}), 128'(0));
      check("rst_acks", 128'({o_if_ack, o_if_err, o_d_ack, o_d_err}), 128'(0));
      check("rst_rdata", 128'({o_if_rdata, o_d_rdata}), 128'(0));

      // Aligned fetch
      do_fetch(32'h100, lat, rd, err);
      check("fetch_lat", 128'(lat), 128'(2));
      check("fetch_rdata", 128'(rd), 128'(32'h0051_0513));
      check("fetch_err", 128'(err), 128'(0));
      check("fetch_ncmd", 128'(cmd_q.size()), 128'(1));
      check("fetch_cmd", 128'(get_cmd(0)), 128'({1'b0, 32'h100, 4'b1111, 32'h0}));

      // SB at 0x203
      do_data(1'b1, 3'b000, 32'h203, 32'h0000_00AB, lat, rd, err);
      check("sb_lat", 128'(lat), 128'(2));
      check("sb_ncmd", 128'(cmd_q.size()), 128'(1));
      check("sb_cmd", 128'(get_cmd(0)), 128'({1'b1, 32'h200, 4'b1000, 32'hAB00_0000}));

      // Split SW at 0x1FE
      do_data(1'b1, 3'b010, 32'h1FE, 32'h1122_3344, lat, rd, err);
      check("sw_split_lat", 128'(lat), 128'(3));
      check("sw_split_ncmd", 128'(cmd_q.size()), 128'(2));
      check("sw_split_cmd0", 128'(get_cmd(0)), 128'({1'b1, 32'h1FC, 4'b1100, 32'h3344_0000}));
      check("sw_split_cmd1", 128'(get_cmd(1)), 128'({1'b1, 32'h200, 4'b0011, 32'h0000_1122}));

      // LW reads back both partial stores at 0x200
      do_data(1'b0, 3'b010, 32'h200, 32'h0, lat, rd, err);
      check("lw200_lat", 128'(lat), 128'(2));
      check("lw200_rdata", 128'(rd), 128'(32'hAB00_1122));

      // Split LH / LHU at 0x2FF
      do_data(1'b0, 3'b001, 32'h2FF, 32'h0, lat, rd, err);
      check("lh_lat", 128'(lat), 128'(3));
      check("lh_rdata", 128'(rd), 128'(32'hFFFF_FF80));
      check("lh_ncmd", 128'(cmd_q.size()), 128'(2));
      check("lh_cmd0", 128'(get_cmd(0)), 128'({1'b0, 32'h2FC, 4'b1000, 32'h0}));
      check("lh_cmd1", 128'(get_cmd(1)), 128'({1'b0, 32'h300, 4'b0001, 32'h0}));
      do_data(1'b0, 3'b101, 32'h2FF, 32'h0, lat, rd, err);
      check("lhu_rdata", 128'(rd), 128'(32'h0000_FF80));
      check("lhu_err", 128'(err), 128'(0));

      // Byte loads at 0x2FF / 0x2FE
      do_data(1'b0, 3'b000, 32'h2FF, 32'h0, lat, rd, err);
      check("lb_rdata", 128'(rd), 128'(32'hFFFF_FF80));
      do_data(1'b0, 3'b100, 32'h2FE, 32'h0, lat, rd, err);
      check("lbu_rdata", 128'(rd), 128'(32'h0000_00AA));

      // Illegal funct3
      do_data(1'b0, 3'b011, 32'h200, 32'h0, lat, rd, err);
      check("ill_ld_lat", 128'(lat), 128'(1));
      check("ill_ld_err", 128'(err), 128'(1));
      check("ill_ld_rdata", 128'(rd), 128'(0));
      check("ill_ld_ncmd", 128'(cmd_q.size()), 128'(0));
      do_data(1'b1, 3'b100, 32'h200, 32'h55, lat, rd, err);
      check("ill_st_err", 128'(err), 128'(1));
      check("ill_st_ncmd", 128'(cmd_q.size()), 128'(0));

      // Misaligned fetch
      do_fetch(32'h102, lat, rd, err);
      check("misfetch_lat", 128'(lat), 128'(1));
      check("misfetch_err", 128'(err), 128'(1));
      check("misfetch_rdata", 128'(rd), 128'(0));
      check("misfetch_ncmd", 128'(cmd_q.size()), 128'(0));

      // Split store that wraps the address space
      do_data(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h5566_7788, lat, rd, err);
      check("wrap_cmd0", 128'(get_cmd(0)), 128'({1'b1, 32'hFFFF_FFFC, 4'b1100, 32'h7788_0000}));
      check("wrap_cmd1", 128'(get_cmd(1)), 128'({1'b1, 32'h0, 4'b0011, 32'h0000_5566}));

      // Reset during ACC1 of a split store
      @(negedge clk);
      cmd_q.delete();
      i_d_req = 1'b1; i_d_we = 1'b1; i_d_funct3 = 3'b010; i_d_addr = 32'h1FE; i_d_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      check("midrst_acc1_en", 128'(o_mem_en), 128'(1));
      i_rst = 1'b1; i_d_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_mem_cmd", 128'({o_mem_en, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata}), 128'(0));
      check("midrst_acks", 128'({o_if_ack, o_if_err, o_d_ack, o_d_err, o_d_rdata}), 128'(0));
      i_rst = 1'b0;
      stray = 0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         if (o_d_ack || o_if_ack) stray++;
      end
      check("midrst_no_ack", 128'(stray), 128'(0));
      check("midrst_ncmd", 128'(cmd_q.size()), 128'(1));
      check("midrst_cmd0", 128'(get_cmd(0)), 128'({1'b1, 32'h1FC, 4'b1100, 32'hBEEF_0000}));
      do_data(1'b0, 3'b010, 32'h1FC, 32'h0, lat, rd, err);
      check("post_rst_lat", 128'(lat), 128'(2));
      check("post_rst_lw1fc", 128'(rd), 128'(32'hBEEF_0000));
      do_data(1'b0, 3'b010, 32'h200, 32'h0, lat, rd, err);
      check("post_rst_lw200", 128'(rd), 128'(32'hAB00_1122));

      // Both requesters held from reset: fetch first, then alternate
      @(negedge clk);
      i_rst = 1'b1;
      i_if_req = 1'b1; i_if_addr = 32'h100;
      i_d_req = 1'b1; i_d_we = 1'b0; i_d_funct3 = 3'b011; i_d_addr = 32'h200;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmd_q.delete();
      i_rst = 1'b0;
      order = 4'b0000; n_ack = 0; n_derr = 0; rd = 32'h0;
      for (int c = 0; c < 40 && n_ack < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (o_if_ack) begin
            order = {order[2:0], 1'b0}; n_ack++; rd = o_if_rdata;
         end
         if (o_d_ack) begin
            order = {order[2:0], 1'b1}; n_ack++;
            if (o_d_err) n_derr++;
         end
      end
      i_if_req = 1'b0; i_d_req = 1'b0;
      repeat (2) @(negedge clk);
      check("rr_nack", 128'(n_ack), 128'(4));
      check("rr_order", 128'(order), 128'(4'b0101));
      check("rr_derr", 128'(n_derr), 128'(2));
      check("rr_fetch_rdata", 128'(rd), 128'(32'h0051_0513));
      check("rr_ncmd", 128'(cmd_q.size()), 128'(2));
      check("rr_cmd0", 128'(get_cmd(0)), 128'({1'b0, 32'h100, 4'b1111, 32'h0}));
      check("rr_cmd1", 128'(get_cmd(1)), 128'({1'b0, 32'h100, 4'b1111, 32'h0}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
